move_input_arbiter: RTL

Sits between the three push-button synchronizer/edge-detector channels (left, right, drop) and the game-control FSM. Generates the periodic sampling strobe that enables the synchronizers. Latches their single-cycle press pulses and arbitrates them into one move command per valid/ready handshake. Applies a post-accept hold-off so that bounce or auto-repeat cannot issue back-to-back moves.

---
 rtl/move_input_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/move_input_arbiter.sv
// move_input_arbiter: generates the sampling strobe, latches button presses and
// issues one move command per valid/ready handshake, followed by a strobe-timed hold-off.
module move_input_arbiter #(
   parameter int TICK_DIV      = 50000,
   parameter int HOLDOFF_TICKS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_en,
   input  logic       left_pulse,
   input  logic       right_pulse,
   input  logic       drop_pulse,
   output logic       sample_en,
   output logic       cmd_valid,
   output logic [1:0] cmd_code,
   input  logic       cmd_ready,
   output logic       busy
);
   localparam int CW = $clog2(TICK_DIV);
   localparam int HW = HOLDOFF_TICKS > 0 ? $clog2(HOLDOFF_TICKS + 1) : 1;

   typedef enum logic [1:0] {IDLE, OFFER, HOLDOFF} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt;
   logic [HW-1:0] hold, hold_n;
   logic [2:0]    pend, pend_n;
   logic [1:0]    code, code_n;

   assign sample_en = cnt == CW'(TICK_DIV - 1);
   assign cmd_valid = state == OFFER;
   assign cmd_code  = cmd_valid ? code : 2'b00;
   assign busy      = state != IDLE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hold  <= '0;
         pend  <= '0;
         code  <= '0;
      end else begin
         state <= state_n;
         cnt   <= sample_en ? '0 : cnt + 1'b1;
         hold  <= hold_n;
         pend  <= pend_n;
         code  <= code_n;
      end

   // pend holds {drop, left, right}; it is only ever non-zero while IDLE
   always_comb begin
      state_n = state;
      pend_n  = game_en ? pend : '0;
      code_n  = code;
      hold_n  = hold;
      case (state)
         IDLE:
            if (game_en) begin
               if (|pend) begin
                  state_n = OFFER;
                  pend_n  = '0;
                  code_n  = pend[2] ? 2'b11 : pend[1] ? 2'b01 : 2'b10;
               end else
                  pend_n = {drop_pulse, left_pulse, right_pulse};
            end
         OFFER:
            if (cmd_ready) begin
               state_n = HOLDOFF;
               hold_n  = HW'(HOLDOFF_TICKS);
            end else if (!game_en)
               state_n = IDLE;
         HOLDOFF:
            if (sample_en) begin
               if (hold == '0) state_n = IDLE;
               else hold_n = hold - 1'b1;
            end
         default: state_n = IDLE;
      endcase
   end
endmodule
